// File: rtl/tcm_arb_pkg.sv
// tcm_arb_pkg: source IDs and request/response bundles shared by the TCM data-port arbiter.
//   SRC_CPU / SRC_DMA : source identifiers stored per outstanding request
//   tcm_req_t         : {addr, data_wr, rd, wr, req_tag}
//   tcm_rsp_t         : {ack, error, data_rd, resp_tag}
package tcm_arb_pkg;
    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_DMA = 1'b1;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data_wr;
        logic        rd;
        logic [3:0]  wr;
        logic [10:0] req_tag;
    } tcm_req_t;
    typedef struct packed {
        logic        ack;
        logic        error;
        logic [31:0] data_rd;
        logic [10:0] resp_tag;
    } tcm_rsp_t;
endpackage

// File: rtl/tcm_arb_fifo.sv
// tcm_arb_fifo: synchronous FIFO of source IDs for in-order response routing.
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   push_i, data_i   : write a source ID
//   pop_i            : drop the head entry
//   full_o           : registered full flag (a pop frees a slot only from the next cycle)
//   empty_o, head_o  : empty flag and oldest stored ID
module tcm_arb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q;
    assign cnt_d   = cnt_q + CW'(push_i) - CW'(pop_i);
    assign full_o  = full_q;
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_ptr_q];
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_i)
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            cnt_q  <= cnt_d;
            full_q <= cnt_d == CW'(DEPTH);
        end
    end
endmodule

// File: rtl/tcm_dport_arbiter.sv
// tcm_dport_arbiter: shares the tcm_mem data port between the CPU and a DMA master.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   cpu_d_* / dma_d_*        : requester ports (addr, data_wr, rd, wr, req_tag in;
//                              accept, ack, error out; data_rd, resp_tag broadcast)
//   mem_d_*                  : port to tcm_mem
//   err_unexp_ack_o          : sticky flag, ack seen with nothing outstanding
// Build option TCM_ARB_RR_EN: round-robin tie-break instead of fixed CPU priority.
module tcm_dport_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int SRC_W       = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] cpu_d_addr_i,
    input  logic [31:0] cpu_d_data_wr_i,
    input  logic        cpu_d_rd_i,
    input  logic [3:0]  cpu_d_wr_i,
    input  logic [10:0] cpu_d_req_tag_i,
    output logic        cpu_d_accept_o,
    output logic        cpu_d_ack_o,
    output logic        cpu_d_error_o,
    output logic [31:0] cpu_d_data_rd_o,
    output logic [10:0] cpu_d_resp_tag_o,
    input  logic [31:0] dma_d_addr_i,
    input  logic [31:0] dma_d_data_wr_i,
    input  logic        dma_d_rd_i,
    input  logic [3:0]  dma_d_wr_i,
    input  logic [10:0] dma_d_req_tag_i,
    output logic        dma_d_accept_o,
    output logic        dma_d_ack_o,
    output logic        dma_d_error_o,
    output logic [31:0] dma_d_data_rd_o,
    output logic [10:0] dma_d_resp_tag_o,
    output logic [31:0] mem_d_addr_o,
    output logic [31:0] mem_d_data_wr_o,
    output logic        mem_d_rd_o,
    output logic [3:0]  mem_d_wr_o,
    output logic [10:0] mem_d_req_tag_o,
    input  logic        mem_d_accept_i,
    input  logic        mem_d_ack_i,
    input  logic        mem_d_error_i,
    input  logic [31:0] mem_d_data_rd_i,
    input  logic [10:0] mem_d_resp_tag_i,
    output logic        err_unexp_ack_o
);
    tcm_req_t         cpu_req, dma_req, win;
    tcm_rsp_t         rsp;
    logic             req_cpu, req_dma, src, tie_src, win_req, issue, accepted, rsp_hit;
    logic             fifo_full, fifo_empty, lock_q, lock_src_q, err_q;
    logic [SRC_W-1:0] head;
    assign cpu_req = '{addr: cpu_d_addr_i, data_wr: cpu_d_data_wr_i, rd: cpu_d_rd_i,
                       wr: cpu_d_wr_i, req_tag: cpu_d_req_tag_i};
    assign dma_req = '{addr: dma_d_addr_i, data_wr: dma_d_data_wr_i, rd: dma_d_rd_i,
                       wr: dma_d_wr_i, req_tag: dma_d_req_tag_i};
    assign rsp     = '{ack: mem_d_ack_i, error: mem_d_error_i, data_rd: mem_d_data_rd_i,
                       resp_tag: mem_d_resp_tag_i};
`ifdef TCM_ARB_RR_EN
    logic last_src_q;
    assign tie_src = (last_src_q == SRC_DMA) ? SRC_CPU : SRC_DMA;
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            last_src_q <= SRC_DMA;
        else if (accepted)
            last_src_q <= src;
    end
`else
    assign tie_src = SRC_CPU;
`endif
    always_comb begin
        req_cpu  = cpu_d_rd_i | (|cpu_d_wr_i);
        req_dma  = dma_d_rd_i | (|dma_d_wr_i);
        // A held lock pins the grant even if its owner has withdrawn; that cycle issues nothing
        src      = lock_q ? lock_src_q : (req_cpu & req_dma) ? tie_src : req_dma ? SRC_DMA : SRC_CPU;
        win      = (src == SRC_DMA) ? dma_req : cpu_req;
        win_req  = (src == SRC_DMA) ? req_dma : req_cpu;
        issue    = rst_ni & win_req & ~fifo_full;
        accepted = issue & mem_d_accept_i;
        rsp_hit  = rst_ni & rsp.ack & ~fifo_empty;
    end
    assign mem_d_addr_o     = win.addr;
    assign mem_d_data_wr_o  = win.data_wr;
    assign mem_d_req_tag_o  = win.req_tag;
    assign mem_d_rd_o       = issue & win.rd;
    assign mem_d_wr_o       = win.wr & {4{issue}};
    assign cpu_d_accept_o   = accepted & (src == SRC_CPU);
    assign dma_d_accept_o   = accepted & (src == SRC_DMA);
    assign cpu_d_ack_o      = rsp_hit & (head == SRC_W'(SRC_CPU));
    assign dma_d_ack_o      = rsp_hit & (head == SRC_W'(SRC_DMA));
    assign cpu_d_error_o    = cpu_d_ack_o & rsp.error;
    assign dma_d_error_o    = dma_d_ack_o & rsp.error;
    assign cpu_d_data_rd_o  = rsp.data_rd;
    assign dma_d_data_rd_o  = rsp.data_rd;
    assign cpu_d_resp_tag_o = rsp.resp_tag;
    assign dma_d_resp_tag_o = rsp.resp_tag;
    assign err_unexp_ack_o  = err_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_src_q <= SRC_CPU;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= win_req & ~accepted;
            lock_src_q <= src;
            if (mem_d_ack_i & fifo_empty)
                err_q <= 1'b1;
        end
    end
    tcm_arb_fifo #(.DEPTH(OUTSTANDING), .W(SRC_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accepted),
        .data_i  (SRC_W'(src)),
        .pop_i   (rsp_hit),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );
endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// tb_tcm_dport_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_tcm_dport_arbiter;
`ifdef TCM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int OUT = 2;
    logic        clk = 1'b0, rst_ni = 1'b0;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic        cpu_rd, dma_rd, mem_acc, mem_ack, mem_err;
    logic [3:0]  cpu_wr, dma_wr;
    logic [10:0] cpu_tag, dma_tag, mem_rtag;
    logic        cpu_acc, cpu_ack, cpu_err, dma_acc, dma_ack, dma_err, err_unexp;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [10:0] cpu_rtag, dma_rtag, mem_tag;
    logic        mem_rd;
    logic [3:0]  mem_wr;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    tcm_dport_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cpu_d_addr_i(cpu_addr), .cpu_d_data_wr_i(cpu_wdata), .cpu_d_rd_i(cpu_rd),
        .cpu_d_wr_i(cpu_wr), .cpu_d_req_tag_i(cpu_tag), .cpu_d_accept_o(cpu_acc),
        .cpu_d_ack_o(cpu_ack), .cpu_d_error_o(cpu_err), .cpu_d_data_rd_o(cpu_rdata),
        .cpu_d_resp_tag_o(cpu_rtag),
        .dma_d_addr_i(dma_addr), .dma_d_data_wr_i(dma_wdata), .dma_d_rd_i(dma_rd),
        .dma_d_wr_i(dma_wr), .dma_d_req_tag_i(dma_tag), .dma_d_accept_o(dma_acc),
        .dma_d_ack_o(dma_ack), .dma_d_error_o(dma_err), .dma_d_data_rd_o(dma_rdata),
        .dma_d_resp_tag_o(dma_rtag),
        .mem_d_addr_o(mem_addr), .mem_d_data_wr_o(mem_wdata), .mem_d_rd_o(mem_rd),
        .mem_d_wr_o(mem_wr), .mem_d_req_tag_o(mem_tag), .mem_d_accept_i(mem_acc),
        .mem_d_ack_i(mem_ack), .mem_d_error_i(mem_err), .mem_d_data_rd_i(mem_rdata),
        .mem_d_resp_tag_i(mem_rtag), .err_unexp_ack_o(err_unexp)
    );

    task automatic idle();
        cpu_addr = 32'h8000_0000; cpu_wdata = '0; cpu_rd = 0; cpu_wr = '0; cpu_tag = 11'h011;
        dma_addr = 32'h8000_0100; dma_wdata = '0; dma_rd = 0; dma_wr = '0; dma_tag = 11'h022;
        mem_acc = 0; mem_ack = 0; mem_err = 0; mem_rdata = '0; mem_rtag = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); rst_ni = 0;
        @(negedge clk); rst_ni = 1;
    endtask

    task automatic test_reset();
        @(negedge clk); idle(); rst_ni = 0;
        cpu_rd = 1; dma_wr = 4'hF; mem_acc = 1; mem_ack = 1; mem_err = 1;
        #1;
        tests++;
        if ({cpu_acc, dma_acc, mem_rd, mem_wr, cpu_ack, dma_ack, cpu_err, dma_err} !== 11'b0) begin
            fails++; $display("FAIL reset_outputs got %b want 0",
                {cpu_acc, dma_acc, mem_rd, mem_wr, cpu_ack, dma_ack, cpu_err, dma_err});
        end
        @(negedge clk); #1;
        tests++;
        if (err_unexp !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_unexp); end
        idle(); rst_ni = 1;
    endtask

    task automatic test_single_read();
        do_reset();
        cpu_rd = 1; mem_acc = 1; #1;
        tests++;
        if ({mem_rd, cpu_acc, dma_acc, mem_addr} !== {3'b110, 32'h8000_0000}) begin
            fails++; $display("FAIL single_issue got %b %b %b %h", mem_rd, cpu_acc, dma_acc, mem_addr);
        end
        @(negedge clk); cpu_rd = 0; mem_acc = 0; mem_ack = 1; mem_rdata = 32'hCAFE_1234; mem_rtag = 11'h155; #1;
        tests++;
        if ({cpu_ack, dma_ack, cpu_err, cpu_rdata, cpu_rtag, dma_rdata} !== {3'b100, 32'hCAFE_1234, 11'h155, 32'hCAFE_1234}) begin
            fails++; $display("FAIL single_ack got ack %b/%b err %b data %h tag %h", cpu_ack, dma_ack, cpu_err, cpu_rdata, cpu_rtag);
        end
        @(negedge clk); mem_ack = 0; #1;
        tests++;
        if (err_unexp !== 1'b0) begin fails++; $display("FAIL single_err got %b want 0", err_unexp); end
    endtask

    task automatic test_contention();
        do_reset();
        cpu_rd = 1; dma_wr = 4'hF; mem_acc = 1; #1;
        tests++;
        if ({cpu_acc, dma_acc, mem_addr} !== {2'b10, 32'h8000_0000}) begin
            fails++; $display("FAIL contend_first got %b%b %h want 10 80000000", cpu_acc, dma_acc, mem_addr);
        end
        @(negedge clk); mem_ack = 1; #1;
        tests++;
        if ({cpu_acc, dma_acc, cpu_ack, dma_ack} !== (RR ? 4'b0110 : 4'b1010)) begin
            fails++; $display("FAIL contend_second got %b%b%b%b", cpu_acc, dma_acc, cpu_ack, dma_ack);
        end
        @(negedge clk); cpu_rd = RR; #1;
        tests++;
        if ({cpu_acc, dma_acc, mem_wr, cpu_ack, dma_ack} !== (RR ? 8'b10_0000_01 : 8'b01_1111_10)) begin
            fails++; $display("FAIL contend_third got %b%b %h %b%b", cpu_acc, dma_acc, mem_wr, cpu_ack, dma_ack);
        end
    endtask

    task automatic test_lock();
        do_reset();
        dma_rd = 1; dma_addr = 32'h8000_0200; #1;
        tests++;
        if ({mem_rd, dma_acc, mem_addr} !== {2'b10, 32'h8000_0200}) begin
            fails++; $display("FAIL lock_c0 got %b%b %h", mem_rd, dma_acc, mem_addr);
        end
        for (int c = 1; c < 3; c++) begin
            @(negedge clk); cpu_rd = 1; #1;
            tests++;
            if ({cpu_acc, dma_acc, mem_addr} !== {2'b00, 32'h8000_0200}) begin
                fails++; $display("FAIL lock_hold%0d got %b%b %h", c, cpu_acc, dma_acc, mem_addr);
            end
        end
        @(negedge clk); mem_acc = 1; #1;
        tests++;
        if ({cpu_acc, dma_acc, mem_addr} !== {2'b01, 32'h8000_0200}) begin
            fails++; $display("FAIL lock_accept got %b%b %h", cpu_acc, dma_acc, mem_addr);
        end
        @(negedge clk); dma_rd = 0; #1;
        tests++;
        if ({cpu_acc, dma_acc, mem_addr} !== {2'b10, 32'h8000_0000}) begin
            fails++; $display("FAIL lock_cpu_after got %b%b %h", cpu_acc, dma_acc, mem_addr);
        end
    endtask

    task automatic test_full();
        do_reset();
        cpu_rd = 1; mem_acc = 1;
        @(negedge clk);
        @(negedge clk); cpu_rd = 0; dma_rd = 1; #1;
        tests++;
        if ({mem_rd, dma_acc} !== 2'b00) begin fails++; $display("FAIL full_block got %b%b want 00", mem_rd, dma_acc); end
        @(negedge clk); mem_ack = 1; #1;
        tests++;
        if ({mem_rd, dma_acc, cpu_ack} !== 3'b001) begin fails++; $display("FAIL full_pop_cycle got %b%b%b want 001", mem_rd, dma_acc, cpu_ack); end
        @(negedge clk); mem_ack = 0; #1;
        tests++;
        if ({mem_rd, dma_acc} !== 2'b11) begin fails++; $display("FAIL full_after_pop got %b%b want 11", mem_rd, dma_acc); end
    endtask

    task automatic test_unexp_ack();
        do_reset();
        mem_ack = 1; #1;
        tests++;
        if ({cpu_ack, dma_ack, err_unexp} !== 3'b000) begin fails++; $display("FAIL unexp_route got %b%b%b want 000", cpu_ack, dma_ack, err_unexp); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); mem_ack = 0; #1;
            tests++;
            if (err_unexp !== 1'b1) begin fails++; $display("FAIL unexp_sticky%0d got %b want 1", c, err_unexp); end
        end
    endtask

    task automatic test_reset_outstanding();
        do_reset();
        cpu_rd = 1; mem_acc = 1; #1;
        tests++;
        if (cpu_acc !== 1'b1) begin fails++; $display("FAIL rst_out_issue got %b want 1", cpu_acc); end
        @(negedge clk); cpu_rd = 0; mem_acc = 0; rst_ni = 0; mem_ack = 1; #1;
        tests++;
        if ({cpu_ack, dma_ack} !== 2'b00) begin fails++; $display("FAIL rst_out_gate got %b%b want 00", cpu_ack, dma_ack); end
        @(negedge clk); rst_ni = 1; #1;
        tests++;
        if ({cpu_ack, dma_ack, err_unexp} !== 3'b000) begin fails++; $display("FAIL rst_out_stray got %b%b%b want 000", cpu_ack, dma_ack, err_unexp); end
        @(negedge clk); mem_ack = 0; #1;
        tests++;
        if (err_unexp !== 1'b1) begin fails++; $display("FAIL rst_out_err got %b want 1", err_unexp); end
    endtask

    task automatic test_random();
        int q[$];
        int lock = -1, w;
        bit last = 1'b1, err = 1'b0, rc, rq, wreq, issue, acc, hit, dest;
        int r;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            r = $urandom % 4; cpu_rd = r == 1; cpu_wr = (r == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
            r = $urandom % 4; dma_rd = r == 1; dma_wr = (r == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
            cpu_addr = $urandom; dma_addr = $urandom; cpu_wdata = $urandom; dma_wdata = $urandom;
            cpu_tag = 11'($urandom); dma_tag = 11'($urandom);
            mem_acc = ($urandom % 4) != 0;
            mem_ack = (q.size() > 0) ? ($urandom % 2 == 1) : ($urandom % 64 == 0);
            mem_err = $urandom % 2 == 1; mem_rdata = $urandom; mem_rtag = 11'($urandom);
            #1;
            rc = cpu_rd | (|cpu_wr); rq = dma_rd | (|dma_wr);
            if (lock >= 0) w = lock;
            else if (rc && rq) w = (RR && !last) ? 1 : 0;
            else w = rq ? 1 : 0;
            wreq = (w == 1) ? rq : rc;
            issue = wreq && q.size() < OUT;
            acc = issue && mem_acc;
            hit = mem_ack && q.size() > 0;
            dest = hit ? q[0][0] : 1'b0;
            tests++;
            if ({mem_rd, mem_wr} !== (issue ? ((w == 1) ? {dma_rd, dma_wr} : {cpu_rd, cpu_wr}) : 5'b0)) begin
                fails++; $display("FAIL rnd_issue n=%0d got %b%h", n, mem_rd, mem_wr);
            end
            if (wreq) begin
                tests++;
                if ({mem_addr, mem_wdata, mem_tag} !== ((w == 1) ? {dma_addr, dma_wdata, dma_tag} : {cpu_addr, cpu_wdata, cpu_tag})) begin
                    fails++; $display("FAIL rnd_mux n=%0d got %h %h %h src %0d", n, mem_addr, mem_wdata, mem_tag, w);
                end
            end
            tests++;
            if ({cpu_acc, dma_acc} !== {acc && w == 0, acc && w == 1}) begin
                fails++; $display("FAIL rnd_accept n=%0d got %b%b want %b%b", n, cpu_acc, dma_acc, acc && w == 0, acc && w == 1);
            end
            tests++;
            if ({cpu_ack, cpu_err, dma_ack, dma_err} !== {hit && !dest, hit && !dest && mem_err, hit && dest, hit && dest && mem_err}) begin
                fails++; $display("FAIL rnd_resp n=%0d got %b%b%b%b hit %b dest %b", n, cpu_ack, cpu_err, dma_ack, dma_err, hit, dest);
            end
            tests++;
            if ({cpu_rdata, cpu_rtag, dma_rdata, dma_rtag} !== {mem_rdata, mem_rtag, mem_rdata, mem_rtag}) begin
                fails++; $display("FAIL rnd_bcast n=%0d got %h %h", n, cpu_rdata, dma_rtag);
            end
            tests++;
            if (err_unexp !== err) begin fails++; $display("FAIL rnd_err n=%0d got %b want %b", n, err_unexp, err); end
            if (hit) void'(q.pop_front());
            if (mem_ack && !hit) err = 1'b1;
            if (acc) begin q.push_back(w); last = w[0]; end
            lock = (wreq && !acc) ? w : -1;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_full();
        test_unexp_ack();
        test_reset_outstanding();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
